eth_rx_pkt_buffer: RTL and testbench
====================================

Name: eth_rx_pkt_buffer

Overview:
- Receive-side packet buffer between the Ethernet MAC receive interface and the register/bus read interface.
- Accepts bytes from the MAC into an internal data FIFO and commits a packet only on a clean EOF, by pushing its byte length into an internal length FIFO.
- Packets that end in error, overflow or are aborted are rolled back. The register side never sees partial packets.

Parameters:
- DATA_AW, 11, data FIFO address width (depth 2^DATA_AW bytes).
- LEN_AW, 4, length FIFO address width (depth 2^LEN_AW entries).

Ports:
- clk_i  in  1  single system clock, rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- clk_en  in  1  clock enable. All state updates occur only when high.
- rx_macwrite  in  1  MAC byte strobe.
- rx_macdata  in  8  MAC receive byte.
- rx_macsof  in  1  first byte of frame, qualified by rx_macwrite.
- rx_maceof  in  1  last byte of frame, qualified by rx_macwrite.
- rx_macerr  in  1  frame bad (CRC/PHY error), sampled with the EOF byte.
- rx_len_fifo_read  in  1  pop the length FIFO.
- rx_len_fifo_data  out  16  head length entry, registered.
- rx_len_fifo_empty  out  1  length FIFO empty.
- rx_data_fifo_read  in  1  pop one committed byte.
- rx_data_fifo_data  out  8  popped byte, registered.
- rx_data_fifo_empty  out  1  no committed bytes available.
- rx_drop_cnt  out  16  count of dropped packets, saturating.
- rx_busy  out  1  high while in RECV, DROP or COMMIT.

Behaviour:
Reset and clock enable:
- rst_i high: all pointers 0, FSM IDLE, rx_len_fifo_data 0, rx_data_fifo_data 0, both empties 1, rx_drop_cnt 0, rx_busy 0.
- Reset mid-packet discards all buffered and committed data.
- clk_en low: all registers hold; inputs are ignored.

Pointers:
- Data FIFO uses (DATA_AW+1)-bit pointers: wr_ptr (speculative), cm_ptr (committed), rd_ptr, and pkt_start = cm_ptr.
- Data full when wr_ptr - rd_ptr == 2^DATA_AW.
- rx_data_fifo_empty = (cm_ptr == rd_ptr).
- Length FIFO uses (LEN_AW+1)-bit pointers with the standard full/empty rule.

FSM states IDLE, RECV, DROP, COMMIT:
- IDLE:
  - rx_macwrite without rx_macsof: ignored.
  - rx_macwrite with rx_macsof and length FIFO full: go DROP. If the same beat also has eof, increment drop count and stay IDLE.
  - Otherwise: write the byte at wr_ptr, wr_ptr++, byte_cnt = 1.
  - If that beat also has eof: go COMMIT, or rollback+drop if rx_macerr. Else go RECV.
- RECV, on each rx_macwrite:
  - sof asserted: abort the current packet (wr_ptr <= cm_ptr, drop++), then handle the beat as a fresh SOF exactly as in IDLE.
  - Data FIFO full: byte not written, wr_ptr <= cm_ptr. Go DROP, or if eof go IDLE with drop++.
  - byte_cnt == 16'hFFFF: treated as overflow, same as the full case.
  - Otherwise: write byte, wr_ptr++, byte_cnt++.
  - eof with rx_macerr: wr_ptr <= cm_ptr, drop++, go IDLE.
  - eof without rx_macerr: go COMMIT.
- DROP:
  - Discard bytes; wr_ptr held at cm_ptr.
  - On eof: drop++, go IDLE.
  - sof while in DROP: counts the dropped packet, then processed as a new SOF.
- COMMIT (one cycle):
  - Write byte_cnt into the length FIFO, len wptr++, cm_ptr <= wr_ptr, go IDLE.
  - rx_macwrite in COMMIT is ignored. The MAC guarantees a gap of at least 1 cycle after EOF.

Drop counter:
- rx_drop_cnt saturates at 16'hFFFF.

Read side:
- rx_data_fifo_read while not empty: rx_data_fifo_data <= mem[rd_ptr] on the same edge, rd_ptr++.
- Data is valid the cycle after the read. A read while empty is ignored and the output holds.
- Length FIFO behaves identically.
- The first byte becomes readable the cycle after COMMIT.
- Simultaneous write/commit and read are both honoured in the same cycle.
- Full is evaluated with the pre-edge rd_ptr (conservative).

Lengths and flags:
- Committed length = number of bytes written, 1..2^DATA_AW.
- Pointers wrap modulo 2^(AW+1).
- rx_busy = (state != IDLE).

Test Plan:
1. Reset, then 64-byte good frame (sof on byte 0, eof on byte 63): COMMIT one cycle after eof; rx_len_fifo_data=64 after one pop; 64 data pops return the bytes in order; both empties return to 1.
2. 20-byte frame with rx_macerr on eof: rx_data_fifo_empty stays 1, rx_len_fifo_empty stays 1, rx_drop_cnt=1. Following 10-byte good frame reads back exactly 10 bytes.
3. DATA_AW=4 (16 bytes): 20-byte frame → no commit, drop_cnt=1. Then 16-byte frame → committed length 16, all 16 bytes readable.
4. LEN_AW=1 (2 entries): 3 good 8-byte frames with no reads → lengths 8,8 queued, third dropped, drop_cnt=1. After popping one length, a fourth frame commits.
5. sof mid-frame after 5 bytes, new frame of 7 bytes: drop_cnt=1, single length entry 7. rx_macwrite pulsed with clk_en low → no state change.
6. Assert rst_i mid-frame after a committed packet: all empties 1, drop_cnt 0, rx_busy 0. Next frame commits normally.

Source files
------------

// File: rtl/eth_rx_pkt_buffer.sv
`default_nettype none
// ============================================================================
// Module   : eth_rx_pkt_buffer
// Brief    : MAC receive packet buffer; commits whole frames, rolls back bad ones
// Revision : 1.0 - initial release
// ============================================================================
module eth_rx_pkt_buffer #(
  parameter int DATA_AW = 11,
  parameter int LEN_AW  = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clk_en,
  input  logic        rx_macwrite,
  input  logic [7:0]  rx_macdata,
  input  logic        rx_macsof,
  input  logic        rx_maceof,
  input  logic        rx_macerr,
  input  logic        rx_len_fifo_read,
  output logic [15:0] rx_len_fifo_data,
  output logic        rx_len_fifo_empty,
  input  logic        rx_data_fifo_read,
  output logic [7:0]  rx_data_fifo_data,
  output logic        rx_data_fifo_empty,
  output logic [15:0] rx_drop_cnt,
  output logic        rx_busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECV   = 2'd1,
    ST_DROP   = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  localparam logic [DATA_AW:0] c_data_depth = {1'b1, {DATA_AW{1'b0}}};
  localparam logic [DATA_AW:0] c_data_one   = {{DATA_AW{1'b0}}, 1'b1};
  localparam logic [LEN_AW:0]  c_len_one    = {{LEN_AW{1'b0}}, 1'b1};

  state_t              r_state, w_state_nx;
  logic [DATA_AW:0]    r_wr_ptr, r_cm_ptr, r_rd_ptr, w_wr_ptr_nx;
  logic [LEN_AW:0]     r_len_wp, r_len_rp;
  logic [15:0]         r_byte_cnt, w_byte_cnt_nx;
  logic [15:0]         r_drop_cnt, w_drop_nx;
  logic [16:0]         w_drop_sum;
  logic [1:0]          w_drop_add;
  logic [7:0]          r_data_dout;
  logic [15:0]         r_len_dout;
  logic [DATA_AW-1:0]  w_wr_addr;
  logic                w_mem_we, w_commit, w_sof_beat;
  logic                w_data_full, w_sof_full, w_len_full;
  logic                w_data_empty, w_len_empty, w_data_rd, w_len_rd;

  logic [7:0]          r_data_mem [0:(1<<DATA_AW)-1];
  logic [15:0]         r_len_mem  [0:(1<<LEN_AW)-1];

  // A fresh frame always starts at the committed pointer, so its room is judged from there
  assign w_data_full  = ((r_wr_ptr - r_rd_ptr) == c_data_depth);
  assign w_sof_full   = ((r_cm_ptr - r_rd_ptr) == c_data_depth);
  assign w_len_full   = (r_len_wp[LEN_AW] != r_len_rp[LEN_AW]) &&
                        (r_len_wp[LEN_AW-1:0] == r_len_rp[LEN_AW-1:0]);
  assign w_data_empty = (r_cm_ptr == r_rd_ptr);
  assign w_len_empty  = (r_len_wp == r_len_rp);
  assign w_data_rd    = rx_data_fifo_read && !w_data_empty;
  assign w_len_rd     = rx_len_fifo_read && !w_len_empty;

  always_comb begin
    w_state_nx    = r_state;
    w_wr_ptr_nx   = r_wr_ptr;
    w_byte_cnt_nx = r_byte_cnt;
    w_wr_addr     = r_wr_ptr[DATA_AW-1:0];
    w_mem_we      = 1'b0;
    w_commit      = 1'b0;
    w_sof_beat    = 1'b0;
    w_drop_add    = 2'd0;
    case (r_state)
      ST_IDLE: begin
        if (rx_macwrite && rx_macsof) w_sof_beat = 1'b1;
      end
      ST_RECV: begin
        if (rx_macwrite) begin
          if (rx_macsof) begin
            w_drop_add = 2'd1;
            w_sof_beat = 1'b1;
          end else if (w_data_full || (r_byte_cnt == 16'hFFFF)) begin
            w_wr_ptr_nx = r_cm_ptr;
            if (rx_maceof) begin
              w_drop_add = 2'd1;
              w_state_nx = ST_IDLE;
            end else begin
              w_state_nx = ST_DROP;
            end
          end else begin
            w_mem_we      = 1'b1;
            w_wr_ptr_nx   = r_wr_ptr + c_data_one;
            w_byte_cnt_nx = r_byte_cnt + 16'd1;
            if (rx_maceof) begin
              if (rx_macerr) begin
                w_wr_ptr_nx = r_cm_ptr;
                w_drop_add  = 2'd1;
                w_state_nx  = ST_IDLE;
              end else begin
                w_state_nx = ST_COMMIT;
              end
            end
          end
        end
      end
      ST_DROP: begin
        w_wr_ptr_nx = r_cm_ptr;
        if (rx_macwrite) begin
          if (rx_macsof) begin
            w_drop_add = 2'd1;
            w_sof_beat = 1'b1;
          end else if (rx_maceof) begin
            w_drop_add = 2'd1;
            w_state_nx = ST_IDLE;
          end
        end
      end
      default: begin
        w_commit   = 1'b1;
        w_state_nx = ST_IDLE;
      end
    endcase

    if (w_sof_beat) begin
      w_wr_addr = r_cm_ptr[DATA_AW-1:0];
      if (w_len_full || w_sof_full) begin
        w_wr_ptr_nx = r_cm_ptr;
        if (rx_maceof) begin
          w_drop_add = w_drop_add + 2'd1;
          w_state_nx = ST_IDLE;
        end else begin
          w_state_nx = ST_DROP;
        end
      end else begin
        w_mem_we      = 1'b1;
        w_wr_ptr_nx   = r_cm_ptr + c_data_one;
        w_byte_cnt_nx = 16'd1;
        if (rx_maceof) begin
          if (rx_macerr) begin
            w_wr_ptr_nx = r_cm_ptr;
            w_drop_add  = w_drop_add + 2'd1;
            w_state_nx  = ST_IDLE;
          end else begin
            w_state_nx = ST_COMMIT;
          end
        end else begin
          w_state_nx = ST_RECV;
        end
      end
    end
  end

  assign w_drop_sum = {1'b0, r_drop_cnt} + {15'd0, w_drop_add};
  assign w_drop_nx  = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];

  // Storage arrays carry no reset so they map onto block RAM
  always_ff @(posedge clk_i) begin
    if (clk_en) begin
      if (w_mem_we) r_data_mem[w_wr_addr] <= rx_macdata;
      if (w_commit) r_len_mem[r_len_wp[LEN_AW-1:0]] <= r_byte_cnt;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_wr_ptr    <= '0;
      r_cm_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_len_wp    <= '0;
      r_len_rp    <= '0;
      r_byte_cnt  <= '0;
      r_drop_cnt  <= '0;
      r_data_dout <= '0;
      r_len_dout  <= '0;
    end else if (clk_en) begin
      r_state    <= w_state_nx;
      r_wr_ptr   <= w_wr_ptr_nx;
      r_byte_cnt <= w_byte_cnt_nx;
      r_drop_cnt <= w_drop_nx;
      if (w_commit) begin
        r_cm_ptr <= r_wr_ptr;
        r_len_wp <= r_len_wp + c_len_one;
      end
      if (w_data_rd) begin
        r_data_dout <= r_data_mem[r_rd_ptr[DATA_AW-1:0]];
        r_rd_ptr    <= r_rd_ptr + c_data_one;
      end
      if (w_len_rd) begin
        r_len_dout <= r_len_mem[r_len_rp[LEN_AW-1:0]];
        r_len_rp   <= r_len_rp + c_len_one;
      end
    end
  end

  assign rx_len_fifo_data   = r_len_dout;
  assign rx_len_fifo_empty  = w_len_empty;
  assign rx_data_fifo_data  = r_data_dout;
  assign rx_data_fifo_empty = w_data_empty;
  assign rx_drop_cnt        = r_drop_cnt;
  assign rx_busy            = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_pkt_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_rx_pkt_buffer
// Brief    : scoreboard bench; three DUT sizes share one MAC stimulus stream
// Revision : 1.0 - initial release
// ============================================================================
module tb_eth_rx_pkt_buffer;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic       rst_i = 1'b1, clk_en = 1'b1;
  logic       rx_macwrite = 1'b0, mac_sof = 1'b0, mac_eof = 1'b0, mac_err = 1'b0;
  logic [7:0] mac_data = 8'd0;
  logic       len_rd = 1'b0, dat_rd = 1'b0;

  logic [15:0] len_d [3];
  logic [7:0]  dat_d [3];
  logic [15:0] drop  [3];
  logic        len_e [3], dat_e [3], busy [3];

  // 0: default sizes, 1: 16-byte data FIFO, 2: 2-entry length FIFO
  eth_rx_pkt_buffer u_dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .clk_en(clk_en),
    .rx_macwrite(rx_macwrite), .rx_macdata(mac_data), .rx_macsof(mac_sof),
    .rx_maceof(mac_eof), .rx_macerr(mac_err),
    .rx_len_fifo_read(len_rd), .rx_len_fifo_data(len_d[0]), .rx_len_fifo_empty(len_e[0]),
    .rx_data_fifo_read(dat_rd), .rx_data_fifo_data(dat_d[0]), .rx_data_fifo_empty(dat_e[0]),
    .rx_drop_cnt(drop[0]), .rx_busy(busy[0]));

  eth_rx_pkt_buffer #(.DATA_AW(4), .LEN_AW(4)) u_dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .clk_en(clk_en),
    .rx_macwrite(rx_macwrite), .rx_macdata(mac_data), .rx_macsof(mac_sof),
    .rx_maceof(mac_eof), .rx_macerr(mac_err),
    .rx_len_fifo_read(len_rd), .rx_len_fifo_data(len_d[1]), .rx_len_fifo_empty(len_e[1]),
    .rx_data_fifo_read(dat_rd), .rx_data_fifo_data(dat_d[1]), .rx_data_fifo_empty(dat_e[1]),
    .rx_drop_cnt(drop[1]), .rx_busy(busy[1]));

  eth_rx_pkt_buffer #(.DATA_AW(11), .LEN_AW(1)) u_dut_c (
    .clk_i(clk_i), .rst_i(rst_i), .clk_en(clk_en),
    .rx_macwrite(rx_macwrite), .rx_macdata(mac_data), .rx_macsof(mac_sof),
    .rx_maceof(mac_eof), .rx_macerr(mac_err),
    .rx_len_fifo_read(len_rd), .rx_len_fifo_data(len_d[2]), .rx_len_fifo_empty(len_e[2]),
    .rx_data_fifo_read(dat_rd), .rx_data_fifo_data(dat_d[2]), .rx_data_fifo_empty(dat_e[2]),
    .rx_drop_cnt(drop[2]), .rx_busy(busy[2]));

  int n_total = 0;
  int n_bad   = 0;
  int sel     = 0;
  logic [7:0]  exp_data_q [$];
  logic [15:0] exp_len_q  [$];

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic beat(input logic [7:0] d, input logic s, input logic e, input logic er);
    rx_macwrite = 1'b1; mac_data = d; mac_sof = s; mac_eof = e; mac_err = er;
    @(posedge clk_i);
    #1;
    rx_macwrite = 1'b0; mac_sof = 1'b0; mac_eof = 1'b0; mac_err = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [7:0] base, input logic er,
                            input logic push, input logic with_eof);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = base + 8'(i);
      beat(b, i == 0, with_eof && (i == n - 1), er && (i == n - 1));
      if (push) exp_data_q.push_back(b);
    end
    if (push) exp_len_q.push_back(16'(n));
  endtask

  task automatic read_len(output logic [15:0] v);
    len_rd = 1'b1;
    @(posedge clk_i);
    #1;
    len_rd = 1'b0;
    v = len_d[sel];
  endtask

  task automatic read_byte(output logic [7:0] v);
    dat_rd = 1'b1;
    @(posedge clk_i);
    #1;
    dat_rd = 1'b0;
    v = dat_d[sel];
  endtask

  task automatic do_reset;
    rst_i = 1'b1;
    idle(2);
    rst_i = 1'b0;
    idle(1);
    exp_data_q.delete();
    exp_len_q.delete();
  endtask

  // Pops every queued length/byte from the selected DUT and checks against the scoreboard
  task automatic test_drain_scoreboard(input string tag);
    logic [15:0] lv, le;
    logic [7:0]  dv, de;
    int nbytes;
    nbytes = exp_data_q.size();
    while (exp_len_q.size() > 0) begin
      le = exp_len_q.pop_front();
      read_len(lv);
      n_total++;
      if (lv !== le) begin n_bad++; $display("FAIL %s_len got=%0d exp=%0d", tag, lv, le); end
    end
    for (int i = 0; i < nbytes; i++) begin
      de = exp_data_q.pop_front();
      read_byte(dv);
      n_total++;
      if (dv !== de) begin n_bad++; $display("FAIL %s_byte%0d got=%h exp=%h", tag, i, dv, de); end
    end
    n_total++;
    if (len_e[sel] !== 1'b1 || dat_e[sel] !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_empty_after got=%b%b exp=11", tag, len_e[sel], dat_e[sel]);
    end
  endtask

  task automatic test_reset;
    do_reset();
    for (int s = 0; s < 3; s++) begin
      n_total++;
      if (len_d[s] !== 16'd0 || dat_d[s] !== 8'd0) begin
        n_bad++; $display("FAIL reset_data dut=%0d got=%h/%h exp=0/0", s, len_d[s], dat_d[s]);
      end
      n_total++;
      if (len_e[s] !== 1'b1 || dat_e[s] !== 1'b1) begin
        n_bad++; $display("FAIL reset_empty dut=%0d got=%b%b exp=11", s, len_e[s], dat_e[s]);
      end
      n_total++;
      if (drop[s] !== 16'd0 || busy[s] !== 1'b0) begin
        n_bad++; $display("FAIL reset_drop_busy dut=%0d got=%0d/%b exp=0/0", s, drop[s], busy[s]);
      end
    end
  endtask

  task automatic test_good_frame;
    sel = 0;
    do_reset();
    send_frame(64, 8'h10, 1'b0, 1'b1, 1'b1);
    n_total++;
    if (busy[0] !== 1'b1 || len_e[0] !== 1'b1) begin
      n_bad++; $display("FAIL commit_cycle busy/len_e got=%b%b exp=11", busy[0], len_e[0]);
    end
    idle(1);
    n_total++;
    if (busy[0] !== 1'b0 || len_e[0] !== 1'b0 || dat_e[0] !== 1'b0) begin
      n_bad++; $display("FAIL after_commit busy/len_e/dat_e got=%b%b%b exp=000",
                        busy[0], len_e[0], dat_e[0]);
    end
    test_drain_scoreboard("good64");
  endtask

  task automatic test_err_frame;
    sel = 0;
    do_reset();
    send_frame(20, 8'h40, 1'b1, 1'b0, 1'b1);
    idle(2);
    n_total++;
    if (dat_e[0] !== 1'b1 || len_e[0] !== 1'b1 || drop[0] !== 16'd1) begin
      n_bad++; $display("FAIL err_rollback got=%b%b drop=%0d exp=11 drop=1", dat_e[0], len_e[0], drop[0]);
    end
    send_frame(10, 8'h80, 1'b0, 1'b1, 1'b1);
    idle(2);
    test_drain_scoreboard("after_err");
  endtask

  task automatic test_data_overflow;
    sel = 1;
    do_reset();
    send_frame(20, 8'h00, 1'b0, 1'b0, 1'b1);
    idle(2);
    n_total++;
    if (len_e[1] !== 1'b1 || dat_e[1] !== 1'b1 || drop[1] !== 16'd1) begin
      n_bad++; $display("FAIL overflow_drop got=%b%b drop=%0d exp=11 drop=1", len_e[1], dat_e[1], drop[1]);
    end
    send_frame(16, 8'hA0, 1'b0, 1'b1, 1'b1);
    idle(2);
    test_drain_scoreboard("full16");
  endtask

  task automatic test_len_full;
    logic [15:0] lv, le;
    sel = 2;
    do_reset();
    send_frame(8, 8'h01, 1'b0, 1'b1, 1'b1);
    idle(1);
    send_frame(8, 8'h21, 1'b0, 1'b1, 1'b1);
    idle(1);
    send_frame(8, 8'h41, 1'b0, 1'b0, 1'b1);
    idle(2);
    n_total++;
    if (drop[2] !== 16'd1) begin n_bad++; $display("FAIL lenfull_drop got=%0d exp=1", drop[2]); end
    le = exp_len_q.pop_front();
    read_len(lv);
    n_total++;
    if (lv !== le) begin n_bad++; $display("FAIL lenfull_first_len got=%0d exp=%0d", lv, le); end
    send_frame(8, 8'h61, 1'b0, 1'b1, 1'b1);
    idle(2);
    n_total++;
    if (drop[2] !== 16'd1 || len_e[2] !== 1'b0) begin
      n_bad++; $display("FAIL lenfull_fourth drop=%0d len_e=%b exp drop=1 len_e=0", drop[2], len_e[2]);
    end
    test_drain_scoreboard("lenfull");
  endtask

  task automatic test_sof_abort_and_clk_en;
    sel = 0;
    do_reset();
    send_frame(5, 8'h20, 1'b0, 1'b0, 1'b0);
    send_frame(7, 8'h60, 1'b0, 1'b1, 1'b1);
    idle(2);
    n_total++;
    if (drop[0] !== 16'd1) begin n_bad++; $display("FAIL abort_drop got=%0d exp=1", drop[0]); end
    test_drain_scoreboard("abort");
    clk_en = 1'b0;
    beat(8'h55, 1'b1, 1'b1, 1'b0);
    idle(1);
    clk_en = 1'b1;
    idle(2);
    n_total++;
    if (len_e[0] !== 1'b1 || dat_e[0] !== 1'b1 || busy[0] !== 1'b0 || drop[0] !== 16'd1) begin
      n_bad++; $display("FAIL clk_en_hold got len_e=%b dat_e=%b busy=%b drop=%0d exp 1 1 0 1",
                        len_e[0], dat_e[0], busy[0], drop[0]);
    end
  endtask

  task automatic test_reset_mid_frame;
    sel = 0;
    do_reset();
    send_frame(6, 8'h30, 1'b1, 1'b0, 1'b1);
    idle(1);
    send_frame(10, 8'h90, 1'b0, 1'b0, 1'b1);
    idle(1);
    send_frame(5, 8'hC0, 1'b0, 1'b0, 1'b0);
    n_total++;
    if (busy[0] !== 1'b1 || len_e[0] !== 1'b0 || drop[0] !== 16'd1) begin
      n_bad++; $display("FAIL pre_reset busy=%b len_e=%b drop=%0d exp 1 0 1", busy[0], len_e[0], drop[0]);
    end
    rst_i = 1'b1;
    #2;
    n_total++;
    if (busy[0] !== 1'b0 || len_e[0] !== 1'b1) begin
      n_bad++; $display("FAIL async_reset busy=%b len_e=%b exp 0 1", busy[0], len_e[0]);
    end
    idle(1);
    rst_i = 1'b0;
    idle(1);
    n_total++;
    if (len_e[0] !== 1'b1 || dat_e[0] !== 1'b1 || drop[0] !== 16'd0 || busy[0] !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset got len_e=%b dat_e=%b drop=%0d busy=%b exp 1 1 0 0",
                        len_e[0], dat_e[0], drop[0], busy[0]);
    end
    send_frame(12, 8'hE0, 1'b0, 1'b1, 1'b1);
    idle(2);
    test_drain_scoreboard("post_reset");
  endtask

  initial begin
    #1;
    test_reset();
    test_good_frame();
    test_err_frame();
    test_data_overflow();
    test_len_full();
    test_sof_abort_and_clk_en();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
